// File: rtl/reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_release_sequencer
// Description : Staged reset-release controller. Holds NUM_STAGES downstream
//               reset domains in reset, then releases them one at a time in
//               order 0..NUM_STAGES-1. Each release waits for the domain's
//               acknowledge, followed by a programmable gap before the next
//               domain is released.
//
// Ports       : ck        - clock, all logic on the rising edge
//               rn        - synchronous active-low reset
//               req_rst   - level software reset request (re-asserts all)
//               ack       - per-domain "out of reset" level, sync to ck
//               rst_n_out - per-domain active-low reset (thermometer 0..01..1)
//               busy      - any rst_n_out bit still low
//               done      - all stages released and acknowledged
//               cur_stage - stage being released/waited, NUM_STAGES when done
//               err       - sticky ack-timeout flag (0 without timeout)
//
// Options     : RSTSEQ_ACK_TIMEOUT_EN - when defined, a stage whose ack has
//               not arrived within TIMEOUT_CYC cycles sets err and is treated
//               as acknowledged. When undefined err is constant 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reset_release_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYC    = 16,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic                          ck,
    input  logic                          rn,
    input  logic                          req_rst,
    input  logic [NUM_STAGES-1:0]         ack,
    output logic [NUM_STAGES-1:0]         rst_n_out,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_STAGES):0]   cur_stage,
    output logic                          err
);

    localparam int c_STAGE_W = $clog2(NUM_STAGES) + 1;

`ifdef RSTSEQ_ACK_TIMEOUT_EN
    localparam logic c_TO_EN = 1'b1;
`else
    localparam logic c_TO_EN = 1'b0;
`endif

    // The release itself happens on the edge that leaves HOLD or GAP, so the
    // REL step of the sequence has no dedicated state (and costs no cycle).
    localparam logic [1:0] c_ST_HOLD = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    // GAP always spends at least one edge, so a zero gap releases the next
    // stage on the edge after the ack was sampled.
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_STAGES-1:0] r_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [c_STAGE_W-1:0]  r_stage;

    logic [CNT_W-1:0]      w_cnt_inc;
    logic [NUM_STAGES-1:0] w_rel_next;
    logic                  w_ack_cur;
    logic                  w_last_stage;
    logic                  w_timeout;

    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    // Shifting a 1 into the thermometer releases exactly the next stage.
    assign w_rel_next   = NUM_STAGES'({r_rst_n, 1'b1});
    // Only the ack of the stage currently waited on is observed.
    assign w_ack_cur    = |(ack & (NUM_STAGES'(1) << r_stage));
    assign w_last_stage = (r_stage == c_STAGE_W'(NUM_STAGES - 1));
    assign w_timeout    = c_TO_EN & (r_cnt == c_TO_LAST);

    always_ff @(posedge ck) begin
        if (!rn || req_rst) begin
            r_state <= c_ST_HOLD;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_stage <= '0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_rst_n <= w_rel_next;
                        r_busy  <= ~&w_rel_next;
                        r_cnt   <= '0;
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                c_ST_WAIT: begin
                    if (w_ack_cur || w_timeout) begin
                        r_cnt <= '0;
                        if (w_last_stage) begin
                            r_done  <= 1'b1;
                            r_stage <= c_STAGE_W'(NUM_STAGES);
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_GAP;
                        end
                    end else if (c_TO_EN) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_rst_n <= w_rel_next;
                        r_busy  <= ~&w_rel_next;
                        r_stage <= r_stage + c_STAGE_W'(1);
                        r_cnt   <= '0;
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_HOLD;
                end
            endcase
        end
    end

    // The timeout flag survives req_rst; only rn clears it.
    always_ff @(posedge ck) begin
        if (!rn) begin
            r_err <= 1'b0;
        end else if (!req_rst && (r_state == c_ST_WAIT) && !w_ack_cur && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign rst_n_out = r_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_stage = r_stage;
    assign err       = c_TO_EN & r_err;

endmodule
`default_nettype wire

// File: tb/tb_reset_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_release_sequencer
// Description : Self-checking bench for reset_release_sequencer. A behavioural
//               model tracks how many stages are released and acknowledged
//               and predicts every output each cycle; directed scenarios pin
//               the documented release timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_release_sequencer;

    localparam int N    = 4;
    localparam int SW   = $clog2(N) + 1;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TO   = 10;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          ck = 1'b0;
    logic          rn;
    logic          req_rst;
    logic [N-1:0]  ack;
    logic [N-1:0]  rst_n_out;
    logic          busy;
    logic          done;
    logic [SW-1:0] cur_stage;
    logic          err;

    logic [N-1:0]  g0_ack;
    logic [N-1:0]  g0_rst_n;
    logic          g0_busy;
    logic          g0_done;
    logic [SW-1:0] g0_stage;
    logic          g0_err;

    assign g0_ack = '1;

    always #5 ck = ~ck;

    reset_release_sequencer #(
        .NUM_STAGES(N), .CNT_W(8), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .ck(ck), .rn(rn), .req_rst(req_rst), .ack(ack),
        .rst_n_out(rst_n_out), .busy(busy), .done(done),
        .cur_stage(cur_stage), .err(err)
    );

    reset_release_sequencer #(
        .NUM_STAGES(N), .CNT_W(8), .HOLD_CYC(HOLD), .GAP_CYC(0), .TIMEOUT_CYC(TO)
    ) dut_g0 (
        .ck(ck), .rn(rn), .req_rst(req_rst), .ack(g0_ack),
        .rst_n_out(g0_rst_n), .busy(g0_busy), .done(g0_done),
        .cur_stage(g0_stage), .err(g0_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: number of stages released, number acknowledged, and
    // edges spent in the current phase.
    int m_rel = 0;
    int m_ack = 0;
    int m_tmr = 0;
    bit m_err = 1'b0;

    // Ack stimulus control
    int cur_dly     = 0;
    int dir_dly     = 2;
    int never_stage = -1;
    bit glitch_en   = 1'b0;

    task automatic new_dly();
        if (dir_dly >= 0)
            cur_dly = ((m_rel - 1) == never_stage) ? 1000 : dir_dly;
        else if (TO_ON && $urandom_range(0, 7) == 0)
            cur_dly = 25;
        else
            cur_dly = $urandom_range(0, 4);
    endtask

    task automatic model_step(input logic s_rn, input logic s_req, input logic [N-1:0] s_ack);
        if (!s_rn) begin
            m_rel = 0; m_ack = 0; m_tmr = 0; m_err = 1'b0;
        end else if (s_req) begin
            m_rel = 0; m_ack = 0; m_tmr = 0;
        end else if (m_rel == 0) begin
            if (m_tmr + 1 >= HOLD) begin
                m_rel = 1; m_tmr = 0; new_dly();
            end else begin
                m_tmr++;
            end
        end else if (m_ack < m_rel) begin
            if (s_ack[m_rel-1]) begin
                m_ack++; m_tmr = 0;
            end else if (TO_ON && (m_tmr + 1 >= TO)) begin
                m_err = 1'b1; m_ack++; m_tmr = 0;
            end else begin
                m_tmr++;
            end
        end else if (m_ack < N) begin
            if (m_tmr + 1 >= ((GAP > 0) ? GAP : 1)) begin
                m_rel++; m_tmr = 0; new_dly();
            end else begin
                m_tmr++;
            end
        end
    endtask

    function automatic logic [N-1:0] gen_ack();
        logic [N-1:0] a;
        a = glitch_en ? N'($urandom) : '0;
        for (int j = 0; j < m_ack; j++)
            if (!glitch_en) a[j] = 1'b1;
        if (m_rel > 0 && m_ack < m_rel)
            a[m_rel-1] = (m_tmr >= cur_dly);
        return a;
    endfunction

    task automatic compare_all();
        logic [N-1:0] e_rst;
        int           e_stage;
        e_rst   = N'((1 << m_rel) - 1);
        e_stage = (m_ack == N) ? N : ((m_rel == 0) ? 0 : m_rel - 1);
        check_eq("rst_n_out", 32'(rst_n_out), 32'(e_rst));
        check_eq("busy", 32'(busy), 32'(m_rel < N));
        check_eq("done", 32'(done), 32'(m_ack == N));
        check_eq("cur_stage", 32'(cur_stage), 32'(e_stage));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("thermometer", 32'(rst_n_out & (rst_n_out + 1'b1)), 32'd0);
    endtask

    // Edge bookkeeping for the directed timing checks
    int           edge_no = 0;
    int           rise_e[N];
    int           g0_rise_e[N];
    int           done_e = -1;
    int           g0_done_e = -1;
    int           err_e = -1;
    logic [N-1:0] prev_rst = '0;
    logic [N-1:0] prev_g0 = '0;
    logic         prev_done = 1'b0;
    logic         prev_g0_done = 1'b0;
    logic         prev_err = 1'b0;

    task automatic step(input logic s_rn, input logic s_req);
        rn      = s_rn;
        req_rst = s_req;
        ack     = gen_ack();
        @(posedge ck);
        model_step(s_rn, s_req, ack);
        #1;
        if (!s_rn) begin
            edge_no = 0;
            for (int i = 0; i < N; i++) begin
                rise_e[i] = -1; g0_rise_e[i] = -1;
            end
            done_e = -1; g0_done_e = -1; err_e = -1;
        end else begin
            edge_no++;
        end
        for (int i = 0; i < N; i++) begin
            if (rst_n_out[i] && !prev_rst[i] && rise_e[i] < 0) rise_e[i] = edge_no;
            if (g0_rst_n[i] && !prev_g0[i] && g0_rise_e[i] < 0) g0_rise_e[i] = edge_no;
        end
        if (done && !prev_done && done_e < 0) done_e = edge_no;
        if (g0_done && !prev_g0_done && g0_done_e < 0) g0_done_e = edge_no;
        if (err && !prev_err && err_e < 0) err_e = edge_no;
        prev_rst     = rst_n_out;
        prev_g0      = g0_rst_n;
        prev_done    = done;
        prev_g0_done = g0_done;
        prev_err     = err;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rn = 1'b0; req_rst = 1'b0; ack = '0;

        // Directed: ack two cycles after each release, no glitches.
        glitch_en = 1'b0;
        dir_dly   = 2;
        repeat (3) step(1'b0, 1'b0);
        check_eq("g0_reset_rst", 32'(g0_rst_n), 32'd0);
        check_eq("g0_reset_busy", 32'(g0_busy), 32'd1);
        for (int k = 0; k < 80 && !(done && g0_done); k++) step(1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rise_edge_%0d", i), 32'(rise_e[i]), 32'(HOLD + 7 * i));
            check_eq($sformatf("g0_rise_edge_%0d", i), 32'(g0_rise_e[i]), 32'(HOLD + 2 * i));
        end
        check_eq("done_edge", 32'(done_e), 32'd40);
        check_eq("g0_done_edge", 32'(g0_done_e), 32'd23);
        check_eq("done_stage", 32'(cur_stage), 32'(N));
        check_eq("g0_done_stage", 32'(g0_stage), 32'(N));
        check_eq("g0_err", 32'(g0_err), 32'd0);

        // Software reset request while stage 2 is current.
        step(1'b0, 1'b0);
        for (int k = 0; k < 80 && cur_stage != SW'(2); k++) step(1'b1, 1'b0);
        check_eq("reached_stage2", 32'(cur_stage), 32'd2);
        step(1'b1, 1'b1);
        check_eq("req_rst_out", 32'(rst_n_out), 32'd0);
        check_eq("req_done", 32'(done), 32'd0);
        check_eq("req_busy", 32'(busy), 32'd1);
        n = 0;
        for (int k = 0; k < 40 && !rst_n_out[0]; k++) begin
            step(1'b1, 1'b0);
            n++;
        end
        check_eq("rel0_after_req", 32'(n), 32'(HOLD));

        // rn asserted in the middle of a gap.
        for (int k = 0; k < 80 && !(m_rel >= 2 && m_ack == m_rel && m_ack < N && m_tmr == 1); k++)
            step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("gap_rn_rst", 32'(rst_n_out), 32'd0);
        check_eq("gap_rn_busy", 32'(busy), 32'd1);
        check_eq("gap_rn_done", 32'(done), 32'd0);
        check_eq("gap_rn_stage", 32'(cur_stage), 32'd0);
        repeat (HOLD - 1) step(1'b1, 1'b0);
        check_eq("no_early_rel", 32'(rst_n_out), 32'd0);
        step(1'b1, 1'b0);
        check_eq("rel0_after_rn", 32'(rst_n_out), 32'd1);

        // Ack timeout on stage 1.
        if (TO_ON) begin
            step(1'b0, 1'b0);
            never_stage = 1;
            for (int k = 0; k < 150 && !done; k++) step(1'b1, 1'b0);
            check_eq("to_err_delay", 32'(err_e - rise_e[1]), 32'(TO));
            check_eq("to_next_rel", 32'(rise_e[2] - err_e), 32'(GAP));
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            check_eq("err_sticky_req", 32'(err), 32'd1);
            step(1'b0, 1'b0);
            check_eq("err_clr_rn", 32'(err), 32'd0);
            never_stage = -1;
        end

        // Randomised ack timing, glitching, resets and requests.
        glitch_en = 1'b1;
        dir_dly   = -1;
        step(1'b0, 1'b0);
        for (int k = 0; k < 3000; k++)
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 199) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
